alu_multi: RTL

Parametrised successor to the two-channel ALU. It has CH channels, a DATA_W-bit datapath, a unified eight-op opcode set, per-channel selectable interrupt conditions and a sticky interrupt controller with a set-priority clear. It sits behind the existing `ifc`-style interface in the ALU verification environment and replaces the fixed A/B channel pair.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_irq_ctrl.sv | 56 +++++
 rtl/alu_multi.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-channel ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OpAnd  = 3'd0,
        OpNand = 3'd1,
        OpOr   = 3'd2,
        OpXor  = 3'd3,
        OpXnor = 3'd4,
        OpNor  = 3'd5,
        OpAdd  = 3'd6,
        OpSub  = 3'd7
    } opcode_t;

    localparam int unsigned COND_ZERO  = 0;
    localparam int unsigned COND_ONES  = 1;
    localparam int unsigned COND_CARRY = 2;

    typedef logic [7:0] data_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned ch_idx_w(input int unsigned ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/alu_irq_ctrl.sv
// Sticky per-channel interrupt pending bits with set-priority clear.
// Optional saturating event counter when ALU_IRQ_CNT_EN is defined.
module alu_irq_ctrl #(
    parameter int unsigned CH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] ev,
    input  logic          irq_clr,
    output logic [CH-1:0] pending,
    output logic          irq
`ifdef ALU_IRQ_CNT_EN
    ,
    output logic [7:0]    irq_cnt
`endif
);

    logic [CH-1:0] pending_d;

    // A set landing on the same edge as a clear wins.
    always_comb begin
        pending_d = irq_clr ? ev : (pending | ev);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_d;
        end
    end

    assign irq = |pending;

`ifdef ALU_IRQ_CNT_EN
    logic [7:0] irq_cnt_d;

    always_comb begin
        irq_cnt_d = irq_cnt;
        if (irq_clr) begin
            irq_cnt_d = (|ev) ? 8'd1 : 8'd0;
        end else if ((|ev) && (irq_cnt != 8'hFF)) begin
            irq_cnt_d = irq_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_cnt <= 8'd0;
        end else begin
            irq_cnt <= irq_cnt_d;
        end
    end
`endif

endmodule

// File: rtl/alu_multi.sv
// CH-channel, DATA_W-bit ALU with per-channel interrupt conditions.
// Define ALU_IRQ_CNT_EN to add the alu_irq_cnt event counter output.
module alu_multi #(
    parameter int unsigned     DATA_W        = 8,
    parameter int unsigned     CH            = 2,
    parameter logic [3*CH-1:0] IRQ_COND_MASK = {CH{3'b111}}
) (
    input  logic              clk,
    input  logic              alu_rst_n,
    input  logic              alu_enable,
    input  logic [CH-1:0]     alu_ch_en,
    input  logic [DATA_W-1:0] alu_in_a,
    input  logic [DATA_W-1:0] alu_in_b,
    input  logic [2:0]        alu_op,
    input  logic              alu_irq_clr,
    output logic [DATA_W-1:0] alu_out,
    output logic              alu_out_valid,
    output logic              alu_irq,
    output logic [CH-1:0]     alu_irq_src,
    output logic              alu_err
`ifdef ALU_IRQ_CNT_EN
    ,
    output logic [7:0]        alu_irq_cnt
`endif
);

    import alu_pkg::*;

    typedef logic [DATA_W-1:0] data_t;

    localparam int unsigned IdxW = ch_idx_w(CH);

    logic [3:0]      sel_cnt;
    logic [IdxW-1:0] sel_idx;
    logic            one_hot;
    logic            multi_sel;
    logic            accept;

    always_comb begin
        sel_cnt = 4'd0;
        sel_idx = '0;
        for (int i = 0; i < CH; i++) begin
            sel_cnt = sel_cnt + 4'(alu_ch_en[i]);
            if (alu_ch_en[i]) begin
                sel_idx = IdxW'(i);
            end
        end
    end

    assign one_hot   = (sel_cnt == 4'd1);
    assign multi_sel = (sel_cnt > 4'd1);
    assign accept    = alu_enable && one_hot;

    data_t           result;
    logic            carry;
    logic [DATA_W:0] sum;
    logic [2:0]      flags_d;

    always_comb begin
        result = '0;
        carry  = 1'b0;
        sum    = '0;
        case (opcode_t'(alu_op))
            OpAnd:  result = alu_in_a & alu_in_b;
            OpNand: result = ~(alu_in_a & alu_in_b);
            OpOr:   result = alu_in_a | alu_in_b;
            OpXor:  result = alu_in_a ^ alu_in_b;
            OpXnor: result = ~(alu_in_a ^ alu_in_b);
            OpNor:  result = ~(alu_in_a | alu_in_b);
            OpAdd: begin
                sum    = {1'b0, alu_in_a} + {1'b0, alu_in_b};
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OpSub: begin
                // Top bit of the widened difference is the borrow (a < b).
                sum    = {1'b0, alu_in_a} - {1'b0, alu_in_b};
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            default: result = '0;
        endcase
    end

    always_comb begin
        flags_d             = 3'b000;
        flags_d[COND_ZERO]  = (result == '0);
        flags_d[COND_ONES]  = &result;
        flags_d[COND_CARRY] = carry;
    end

    logic [2:0]      flags_q;
    logic [IdxW-1:0] idx_q;

    always_ff @(posedge clk or negedge alu_rst_n) begin
        if (!alu_rst_n) begin
            alu_out       <= '0;
            alu_out_valid <= 1'b0;
            alu_err       <= 1'b0;
            flags_q       <= 3'b000;
            idx_q         <= '0;
        end else begin
            alu_out_valid <= accept;
            alu_err       <= alu_enable && multi_sel;
            if (accept) begin
                alu_out <= result;
                flags_q <= flags_d;
                idx_q   <= sel_idx;
            end
        end
    end

    // Events come from the registered flags, so irq trails the result by one cycle.
    logic [CH-1:0] ev;

    always_comb begin
        ev = '0;
        for (int k = 0; k < CH; k++) begin
            if (alu_out_valid && (idx_q == IdxW'(k))) begin
                ev[k] = |(flags_q & IRQ_COND_MASK[3*k +: 3]);
            end
        end
    end

    alu_irq_ctrl #(
        .CH(CH)
    ) u_irq_ctrl (
        .clk     (clk),
        .rst_n   (alu_rst_n),
        .ev      (ev),
        .irq_clr (alu_irq_clr),
        .pending (alu_irq_src),
        .irq     (alu_irq)
`ifdef ALU_IRQ_CNT_EN
        ,
        .irq_cnt (alu_irq_cnt)
`endif
    );

endmodule
